// File: rtl/reg_file_port_master.sv
// rtl/reg_file_port_master.sv - command-driven master for a register-file port
// Serves READ/WRITE/CLEAR/DUMP commands; reads come back as a ready/valid response stream.
module reg_file_port_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_last,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [ADDR_WIDTH-1:0] rf_raddr,
  input  logic [DATA_WIDTH-1:0] rf_rdata
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_DUMP  = 2'b11;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

  typedef enum logic [2:0] {IDLE, WR, CLR, RD, RSP} state_t;

  state_t                state, next_state;
  logic                  ready_q;
  logic [1:0]            op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] rd_idx;

  assign accept    = cmd_valid && cmd_ready;
  assign rd_idx    = (op_q == OP_DUMP) ? cnt : addr_q;
  // Registered so cmd_ready stays low until the first edge after reset is released.
  assign cmd_ready = ready_q;
  assign rsp_valid = (state == RSP);

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_WRITE: next_state = WR;
            OP_CLEAR: next_state = CLR;
            default:  next_state = RD;
          endcase
        end
      end
      WR:      next_state = IDLE;
      CLR:     if (cnt == LAST_IDX) next_state = IDLE;
      RD:      next_state = RSP;
      RSP:     if (rsp_ready) next_state = rsp_last ? IDLE : RD;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    rf_wen   = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    rf_raddr = '0;
    case (state)
      WR: begin
        if (addr_q != '0) begin
          rf_wen   = 1'b1;
          rf_waddr = addr_q;
          rf_wdata = data_q;
        end
      end
      CLR: begin
        rf_wen   = 1'b1;
        rf_waddr = cnt;
      end
      RD:      rf_raddr = rd_idx;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ready_q  <= 1'b0;
      op_q     <= OP_READ;
      addr_q   <= '0;
      data_q   <= '0;
      cnt      <= '0;
      rsp_addr <= '0;
      rsp_data <= '0;
      rsp_last <= 1'b0;
    end else begin
      state   <= next_state;
      ready_q <= (next_state == IDLE);
      if (accept) begin
        op_q   <= cmd_op;
        addr_q <= cmd_addr;
        data_q <= cmd_data;
        // Index 0 is never cleared, so CLEAR starts its sweep at 1.
        cnt    <= (cmd_op == OP_CLEAR) ? ADDR_WIDTH'(1) : '0;
      end
      if (state == CLR && cnt != LAST_IDX) cnt <= cnt + 1'b1;
      if (state == RD) begin
        rsp_data <= rf_rdata;
        rsp_addr <= rd_idx;
        rsp_last <= (op_q != OP_DUMP) || (cnt == LAST_IDX);
      end
      if (state == RSP && rsp_ready && !rsp_last) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_file_port_master.sv
// tb/tb_reg_file_port_master.sv - self-checking bench for reg_file_port_master
// Table vectors, random commands against a command-level model, and reset corner cases.
module tb_reg_file_port_master;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NREG = 32;
  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_CL = 2'b10;
  localparam logic [1:0] OP_DU = 2'b11;

  logic          clk, rst;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid, rsp_ready, rsp_last;
  logic [AW-1:0] rsp_addr;
  logic [DW-1:0] rsp_data;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr, rf_raddr;
  logic [DW-1:0] rf_wdata, rf_rdata;

  reg_file_port_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
    .rsp_data(rsp_data), .rsp_last(rsp_last),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file the DUT drives; model_mem holds what it should contain.
  logic          mem_init;
  logic [DW-1:0] env_mem [NREG];
  logic [DW-1:0] model_mem [NREG];
  assign rf_rdata = env_mem[rf_raddr];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < NREG; i++) env_mem[i] <= '0;
    end else if (rf_wen) begin
      env_mem[rf_waddr] <= rf_wdata;
    end
  end

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  word_t exp_w[$], got_w[$], exp_r[$], got_r[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_cmd(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    exp_w.delete();
    exp_r.delete();
    case (op)
      OP_WR: if (addr != 0) begin
        exp_w.push_back('{addr: addr, data: data, last: 1'b0});
        model_mem[addr] = data;
      end
      OP_RD: exp_r.push_back('{addr: addr, data: model_mem[addr], last: 1'b1});
      OP_CL: for (int i = 1; i < NREG; i++) begin
        exp_w.push_back('{addr: AW'(i), data: '0, last: 1'b0});
        model_mem[i] = '0;
      end
      default: for (int i = 0; i < NREG; i++)
        exp_r.push_back('{addr: AW'(i), data: model_mem[i], last: (i == NREG - 1)});
    endcase
  endtask

  // Issue one command at a post-edge sample point and watch it until cmd_ready returns.
  task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input int ready_pct, input int exp_busy);
    int    busy;
    bit    prev_hs, have_hold;
    word_t hold, cur;
    busy = 0;
    while (!cmd_ready && busy < 200) begin
      @(posedge clk); #1;
      busy++;
    end
    chk("cmd_ready_before_issue", cmd_ready, 1);
    model_cmd(op, addr, data);
    got_w.delete();
    got_r.delete();
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
    @(posedge clk); #1;
    busy = 0; prev_hs = 0; have_hold = 0; hold = '0;
    forever begin
      cur = '{addr: rsp_addr, data: rsp_data, last: rsp_last};
      if (prev_hs) chk("rsp_valid_drop_after_hs", rsp_valid, 0);
      if (have_hold) begin
        chk("stall_rsp_valid", rsp_valid, 1);
        chk("stall_rsp_word", cur, hold);
      end
      if (cmd_ready) break;
      if (busy >= 2000) break;
      busy++;
      if (rf_wen) got_w.push_back('{addr: rf_waddr, data: rf_wdata, last: 1'b0});
      else chk("idle_write_bus_zero", {rf_waddr, rf_wdata}, 0);
      if (rf_wen || rsp_valid) chk("raddr_zero_outside_rd", rf_raddr, 0);
      rsp_ready = ($urandom_range(99) < ready_pct);
      cmd_valid = 1'($urandom);
      cmd_op = 2'($urandom);
      cmd_addr = AW'($urandom);
      cmd_data = $urandom;
      prev_hs = 0; have_hold = 0;
      if (rsp_valid) begin
        if (rsp_ready) begin
          got_r.push_back(cur);
          prev_hs = 1;
        end else begin
          hold = cur;
          have_hold = 1;
        end
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    chk("cmd_ready_after_cmd", cmd_ready, 1);
    if (exp_busy >= 0) chk("busy_cycles", busy, exp_busy);
    chk("write_count", got_w.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) chk("write_word", got_w[i], exp_w[i]);
    chk("rsp_count", got_r.size(), exp_r.size());
    for (int i = 0; i < exp_r.size() && i < got_r.size(); i++) chk("rsp_word", got_r[i], exp_r[i]);
  endtask

  function automatic int busy_of(input logic [1:0] op);
    if (op == OP_WR) return 1;
    if (op == OP_CL) return NREG - 1;
    return -1;
  endfunction

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            exp_busy;
    bit            chk_data;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n;
    vecs[0] = '{OP_WR, 5'd5,  32'hDEADBEEF, 1,  0, 32'h0};
    vecs[1] = '{OP_RD, 5'd5,  32'h0,        -1, 1, 32'hDEADBEEF};
    vecs[2] = '{OP_WR, 5'd0,  32'h12345678, 1,  0, 32'h0};
    vecs[3] = '{OP_RD, 5'd0,  32'h0,        -1, 1, 32'h0};
    vecs[4] = '{OP_WR, 5'd31, 32'hA5A5A5A5, 1,  0, 32'h0};
    vecs[5] = '{OP_CL, 5'd9,  32'hFFFFFFFF, 31, 0, 32'h0};
    vecs[6] = '{OP_RD, 5'd5,  32'h0,        -1, 1, 32'h0};
    vecs[7] = '{OP_RD, 5'd31, 32'h0,        -1, 1, 32'h0};
    for (int i = 0; i < NREG; i++) model_mem[i] = '0;

    rst = 1'b1; mem_init = 1'b1;
    cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_data = 0; rsp_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rf_bus", {rf_wen, rf_waddr, rf_wdata, rf_raddr}, 0);
    chk("reset_rsp_word", {rsp_addr, rsp_data, rsp_last}, 0);
    rst = 1'b0; mem_init = 1'b0;
    #1 chk("cmd_ready_low_until_edge", cmd_ready, 0);
    @(posedge clk); #1;
    chk("cmd_ready_after_release", cmd_ready, 1);

    foreach (vecs[i]) begin
      run_cmd(vecs[i].op, vecs[i].addr, vecs[i].data, 60, vecs[i].exp_busy);
      if (vecs[i].chk_data) begin
        chk("vec_rsp_present", got_r.size(), 1);
        if (got_r.size() > 0) chk("vec_rsp_data", got_r[0].data, vecs[i].exp_data);
      end
    end

    for (int k = 0; k < 40; k++) begin
      logic [1:0] op;
      n = $urandom_range(99);
      op = (n < 55) ? OP_WR : (n < 85) ? OP_RD : (n < 95) ? OP_DU : OP_CL;
      run_cmd(op, AW'($urandom), $urandom, $urandom_range(20, 90), busy_of(op));
    end
    run_cmd(OP_DU, 0, 0, 40, -1);

    // Reset in the 10th CLEAR cycle.
    cmd_valid = 1'b1; cmd_op = OP_CL; cmd_addr = 0; cmd_data = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      chk("clear_wen", rf_wen, 1);
      chk("clear_waddr", rf_waddr, c);
      if (c < 10) begin
        @(posedge clk); #1;
      end
    end
    rst = 1'b1;
    #1;
    chk("rst_async_wen", rf_wen, 0);
    chk("rst_async_cmd_ready", cmd_ready, 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("rst_hold_wen", rf_wen, 0);
    end
    rst = 1'b0;
    #1 chk("rst_release_ready_low", cmd_ready, 0);
    @(posedge clk); #1;
    chk("rst_release_ready_high", cmd_ready, 1);
    chk("rst_release_wen", rf_wen, 0);
    for (int i = 1; i < 10; i++) model_mem[i] = '0;
    run_cmd(OP_WR, 5'd3, 32'hCAFEF00D, 50, 1);
    run_cmd(OP_DU, 0, 0, 70, -1);

    // Reset while a DUMP response is stalled.
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = OP_DU;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("dump_rsp_seen", rsp_valid, 1);
    rst = 1'b1;
    #1 chk("rst_async_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("post_rst_no_rsp", rsp_valid, 0);
      chk("post_rst_ready", cmd_ready, 1);
    end
    run_cmd(OP_RD, 5'd3, 0, 50, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_port_master.md
REG_FILE_PORT_MASTER -- requirements
Module: reg_file_port_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register address width (2^ADDR_WIDTH registers).
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  sole clock; all state updates on posedge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 cmd_valid  input  1  command present.
REQ-007 cmd_ready  output  1  master can accept a command.
REQ-008 cmd_op  input  2  00 READ, 01 WRITE, 10 CLEAR, 11 DUMP.
REQ-009 cmd_addr  input  ADDR_WIDTH  target register for READ/WRITE.
REQ-010 cmd_data  input  DATA_WIDTH  write data for WRITE.
REQ-011 rsp_valid  output  1  response word present.
REQ-012 rsp_ready  input  1  consumer accepts response.
REQ-013 rsp_addr  output  ADDR_WIDTH  register index of response word.
REQ-014 rsp_data  output  DATA_WIDTH  register contents.
REQ-015 rsp_last  output  1  final word of the current READ/DUMP.
REQ-016 rf_wen  output  1  register-file write enable.
REQ-017 rf_waddr  output  ADDR_WIDTH  register-file write address.
REQ-018 rf_wdata  output  DATA_WIDTH  register-file write data.
REQ-019 rf_raddr  output  ADDR_WIDTH  register-file read address.
REQ-020 rf_rdata  input  DATA_WIDTH  register-file read data, combinational from rf_raddr.

Function
REQ-021 SHALL implement states IDLE, WR, CLR, RD, RSP; a command transfers only on a clk edge with cmd_valid && cmd_ready.
REQ-022 cmd_ready SHALL be 1 only in IDLE; all other inputs are ignored while cmd_ready=0.
REQ-023 SHALL register op/addr/data at acceptance; later cmd_* changes have no effect.
REQ-024 WRITE: IDLE->WR; in WR for exactly one cycle, rf_wen=1, rf_waddr=addr, rf_wdata=data; then IDLE. Accepted at edge N means rf_wen is high in cycle N+1 and cmd_ready returns in cycle N+2.
REQ-025 WRITE to address 0 SHALL still take the WR cycle but keep rf_wen=0.
REQ-026 CLEAR: IDLE->CLR; index counter steps 1..2^ADDR_WIDTH-1, one per cycle, with rf_wen=1, rf_wdata=0; after the last index, IDLE. Duration is 31 cycles at default width, with no response.
REQ-027 READ: IDLE->RD; in RD, rf_raddr=addr, and at the RD->RSP edge rsp_data<=rf_rdata, rsp_addr<=addr, rsp_last<=1.
REQ-028 DUMP: counter reset to 0; RD/RSP alternate per index. rsp_last=1 only for index 2^ADDR_WIDTH-1. A handshake on the last index ->IDLE; otherwise the counter increments and the FSM goes ->RD.
REQ-029 In RSP, rsp_valid=1; rsp_data/rsp_addr/rsp_last SHALL stay stable until rsp_valid && rsp_ready; rsp_valid SHALL drop the cycle after the handshake.
REQ-030 rsp_ready held low SHALL stall indefinitely without data loss; rsp_ready outside RSP has no effect.
REQ-031 rf_wen SHALL be 0 in every state except WR (addr!=0) and CLR.
REQ-032 rf_raddr SHALL be 0 outside RD; rf_waddr and rf_wdata SHALL be 0 when rf_wen=0.
REQ-033 The counter SHALL not wrap past 2^ADDR_WIDTH-1 and SHALL be reloaded at each CLEAR/DUMP acceptance.
REQ-034 A command SHALL NOT be accepted in the same cycle the previous one completes; the FSM first re-enters IDLE.

Reset
REQ-035 rst=1 SHALL immediately force IDLE and set every output to 0, including cmd_ready, rf_wen and rsp_valid, independent of clk.
REQ-036 Reset mid-CLEAR/DUMP/RSP SHALL abandon the operation with no further rf_wen pulses or response words; cmd_ready SHALL rise at the first clk edge after rst deasserts.

Verification
REQ-037 WRITE addr=5 data=0xDEADBEEF -> exactly one cycle with rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF; a later READ 5 -> rsp_data=0xDEADBEEF, rsp_addr=5, rsp_last=1.
REQ-038 WRITE addr=0 data=0x12345678 -> rf_wen stays 0; READ 0 against a model returning 0 -> rsp_data=0.
REQ-039 CLEAR -> 31 consecutive rf_wen pulses with addresses 1..31 and wdata=0; cmd_ready=0 throughout, then 1.
REQ-040 DUMP with rsp_ready toggled randomly -> 32 words, addr 0..31 in order, data matching the model, outputs stable while stalled, rsp_last only on addr 31.
REQ-041 Assert rst in the 10th CLEAR cycle -> rf_wen drops immediately, and no pulse follows; after release, WRITE 3 executes normally.
REQ-042 Change cmd_addr/cmd_data while busy -> no effect on rf_* or rsp_* outputs.
